// File: rtl/data_memory_unit_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Widths follow the memory's DATA_WIDTH and ADDRESS_WIDTH parameters.
interface data_memory_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                      request_valid;
    logic                      request_ready;
    logic                      memory_read;
    logic                      memory_write;
    logic [ADDRESS_WIDTH-1:0]  address;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   byte_enable;
    logic                      response_valid;
    logic [DATA_WIDTH-1:0]     read_data;
    logic                      access_error;
    logic                      busy;
    logic                      error_clear;
    logic                      error_pending;
    logic [ADDRESS_WIDTH-1:0]  error_address;

    modport master (
        output request_valid, memory_read, memory_write, address, write_data,
               byte_enable, error_clear,
        input  request_ready, response_valid, read_data, access_error, busy,
               error_pending, error_address
    );

    modport slave (
        input  request_valid, memory_read, memory_write, address, write_data,
               byte_enable, error_clear,
        output request_ready, response_valid, read_data, access_error, busy,
               error_pending, error_address
    );
endinterface

// File: rtl/data_memory_unit.sv
// Byte-enabled data memory with fixed read latency and a one-outstanding valid/ready handshake.
// Define DMEM_ERROR_CAPTURE_EN to enable sticky capture of the first faulting address.
module data_memory_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 1
) (
    input  logic                  system_clock,
    input  logic                  reset,
    data_memory_unit_if.slave     bus,
    output logic [1:0]            dbg_state_o
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFFSET = $clog2(BYTES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESPOND = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic misaligned, out_of_range, fault, accept;

    assign word_idx     = bus.address[OFFSET+IDX_W-1:OFFSET];
    assign misaligned   = bus.address[OFFSET-1:0] != '0;
    assign out_of_range = (bus.address >> (OFFSET + IDX_W)) != '0;
    assign fault        = misaligned | out_of_range | (bus.memory_read & bus.memory_write);
    // Gating with reset keeps a request held during reset from touching the array.
    assign accept       = reset && (state_q == IDLE) && bus.request_valid &&
                          (bus.memory_read || bus.memory_write);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = LAT_M1;
                    state_d = (READ_LATENCY == 1) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                cnt_d = 2'(cnt_q - 2'd1);
                if (cnt_q == 2'd1) state_d = RESPOND;
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                err_q   <= fault;
                rdata_q <= (fault || bus.memory_write) ? '0 : mem[word_idx];
            end
        end
    end

    // The array is deliberately left out of reset so contents survive it.
    always_ff @(posedge system_clock) begin
        if (accept && bus.memory_write && !fault) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.byte_enable[b]) mem[word_idx][8*b +: 8] <= bus.write_data[8*b +: 8];
            end
        end
    end

    assign bus.request_ready  = (state_q == IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.response_valid = (state_q == RESPOND);
    assign bus.read_data      = (state_q == RESPOND) ? rdata_q : '0;
    assign bus.access_error   = (state_q == RESPOND) && err_q;
    assign dbg_state_o        = state_q;

`ifdef DMEM_ERROR_CAPTURE_EN
    logic [ADDRESS_WIDTH-1:0] addr_q, eaddr_q;
    logic                     pend_q;

    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            eaddr_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            if (accept) addr_q <= bus.address;
            // A new fault wins over a simultaneous clear.
            if (state_q == RESPOND && err_q && (!pend_q || bus.error_clear)) begin
                pend_q  <= 1'b1;
                eaddr_q <= addr_q;
            end else if (bus.error_clear) begin
                pend_q  <= 1'b0;
                eaddr_q <= '0;
            end
        end
    end

    assign bus.error_pending = pend_q;
    assign bus.error_address = eaddr_q;
`else
    logic unused_error_clear;
    assign unused_error_clear = bus.error_clear;
    assign bus.error_pending  = 1'b0;
    assign bus.error_address  = '0;
`endif
endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: three instances at read latencies 1, 3 and 4
// share one stimulus bus, selected by sel.
module tb_data_memory_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int sel = 1;
    logic        req_valid = 0, req_rd = 0, req_wr = 0, err_clear = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_be = 0;
    logic        req_ready, resp_valid, acc_err, busy, err_pend;
    logic [31:0] rdata, err_addr;
    logic [1:0]  st1, st3, st4;

    int n_vec = 0;
    int n_miss = 0;
    logic [31:0] exp_q[$];

    data_memory_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus1 ();
    data_memory_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus3 ();
    data_memory_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus4 ();

    assign bus1.request_valid = req_valid && (sel == 1);
    assign bus1.memory_read   = req_rd;
    assign bus1.memory_write  = req_wr;
    assign bus1.address       = req_addr;
    assign bus1.write_data    = req_wdata;
    assign bus1.byte_enable   = req_be;
    assign bus1.error_clear   = err_clear && (sel == 1);

    assign bus3.request_valid = req_valid && (sel == 3);
    assign bus3.memory_read   = req_rd;
    assign bus3.memory_write  = req_wr;
    assign bus3.address       = req_addr;
    assign bus3.write_data    = req_wdata;
    assign bus3.byte_enable   = req_be;
    assign bus3.error_clear   = err_clear && (sel == 3);

    assign bus4.request_valid = req_valid && (sel == 4);
    assign bus4.memory_read   = req_rd;
    assign bus4.memory_write  = req_wr;
    assign bus4.address       = req_addr;
    assign bus4.write_data    = req_wdata;
    assign bus4.byte_enable   = req_be;
    assign bus4.error_clear   = err_clear && (sel == 4);

    data_memory_unit #(.READ_LATENCY(1)) u_l1 (
        .system_clock(clk), .reset(rst_n), .bus(bus1.slave), .dbg_state_o(st1));
    data_memory_unit #(.READ_LATENCY(3)) u_l3 (
        .system_clock(clk), .reset(rst_n), .bus(bus3.slave), .dbg_state_o(st3));
    data_memory_unit #(.READ_LATENCY(4)) u_l4 (
        .system_clock(clk), .reset(rst_n), .bus(bus4.slave), .dbg_state_o(st4));

    always_comb begin
        req_ready = bus1.request_ready;  resp_valid = bus1.response_valid;
        rdata     = bus1.read_data;      acc_err    = bus1.access_error;
        busy      = bus1.busy;           err_pend   = bus1.error_pending;
        err_addr  = bus1.error_address;
        case (sel)
            3: begin
                req_ready = bus3.request_ready;  resp_valid = bus3.response_valid;
                rdata     = bus3.read_data;      acc_err    = bus3.access_error;
                busy      = bus3.busy;           err_pend   = bus3.error_pending;
                err_addr  = bus3.error_address;
            end
            4: begin
                req_ready = bus4.request_ready;  resp_valid = bus4.response_valid;
                rdata     = bus4.read_data;      acc_err    = bus4.access_error;
                busy      = bus4.busy;           err_pend   = bus4.error_pending;
                err_addr  = bus4.error_address;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One complete transaction: present, wait bounded for the response, check it.
    task automatic do_req(input int s, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_err, input string tag);
        int lat;
        logic [31:0] exp_d;
        sel = s;
        exp_q.push_back(exp_data);
        @(negedge clk);
        req_valid = 1; req_rd = rd; req_wr = wr; req_addr = a; req_wdata = wd; req_be = be;
        check({tag, "_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0; req_rd = 0; req_wr = 0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_d = exp_q.pop_front();
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, rdata, exp_d);
        check({tag, "_err"}, acc_err, exp_err);
        @(posedge clk); #1;
        check({tag, "_pulse"}, resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", acc_err, 0);
        check("rst_epend", err_pend, 0);
        check("rst_eaddr", err_addr, 0);

        // Full-word write/read and partial byte-enable merge at latency 1.
        do_req(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 0, "wr10");
        do_req(1, 1, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0, "rd10");
        do_req(1, 0, 1, 32'h20, 32'h11223344, 4'hF, 1, 32'h0, 0, "wr20");
        do_req(1, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 32'h0, 0, "wr20be");
        do_req(1, 1, 0, 32'h20, 32'h0, 4'h0, 1, 32'h11BB33DD, 0, "rd20");
        do_req(1, 0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 1, 32'h0, 0, "wr20be0");
        do_req(1, 1, 0, 32'h20, 32'h0, 4'h0, 1, 32'h11BB33DD, 0, "rd20b");

        // Valid with neither read nor write is not accepted.
        sel = 1;
        @(negedge clk); req_valid = 1;
        @(posedge clk); #1;
        check("noop_busy", busy, 0);
        check("noop_ready", req_ready, 1);
        req_valid = 0;

        // Fault cases.
        do_req(1, 0, 1, 32'h13, 32'h12345678, 4'hF, 1, 32'h0, 1, "mis13");
        do_req(1, 0, 1, 32'h1000, 32'h12345678, 4'hF, 1, 32'h0, 1, "oor1000");
        do_req(1, 1, 1, 32'h10, 32'h0, 4'hF, 1, 32'h0, 1, "rdwr");
        do_req(1, 1, 0, 32'h1000, 32'h0, 4'h0, 1, 32'h0, 1, "rdoor");
        do_req(1, 1, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0, "rd10post");

`ifdef DMEM_ERROR_CAPTURE_EN
        check("cap_pend", err_pend, 1);
        check("cap_addr", err_addr, 32'h13);
        @(negedge clk); err_clear = 1;
        @(posedge clk); #1; err_clear = 0;
        check("clr_pend", err_pend, 0);
        check("clr_addr", err_addr, 0);
`else
        check("nocap_pend", err_pend, 0);
        check("nocap_addr", err_addr, 0);
`endif

        // Latency 3: cycle-by-cycle handshake with an ignored request during busy.
        do_req(3, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 32'h0, 0, "l3_wr");
        sel = 3;
        @(negedge clk);
        req_valid = 1; req_rd = 1; req_wr = 0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_rd = 0; req_wr = 1; req_wdata = 32'h0; req_be = 4'hF;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("l3_busy%0d", i), busy, 1);
            check($sformatf("l3_ready%0d", i), req_ready, 0);
            check($sformatf("l3_resp%0d", i), resp_valid, (i == 3));
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        check("l3_rdata", rdata, 32'hDEADBEEF);
        req_valid = 0; req_wr = 0;
        @(posedge clk); #1;
        check("l3_idle", req_ready, 1);
        do_req(3, 1, 0, 32'h10, 32'h0, 4'h0, 3, 32'hDEADBEEF, 0, "l3_rd");

        // Latency 4: reset in the middle of a read drops the response.
        do_req(4, 0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 4, 32'h0, 0, "l4_wr");
        sel = 4;
        @(negedge clk);
        req_valid = 1; req_rd = 1; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 0; req_rd = 0;
        @(posedge clk); #1;
        check("l4_wait_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        check("l4_rst_ready", req_ready, 1);
        check("l4_rst_busy", busy, 0);
        check("l4_rst_resp", resp_valid, 0);
        check("l4_rst_rdata", rdata, 0);
        check("l4_rst_err", acc_err, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("l4_rst_noresp%0d", i), resp_valid, 0);
        end
        @(negedge clk); rst_n = 1;
        do_req(4, 1, 0, 32'h40, 32'h0, 4'h0, 4, 32'hCAFEF00D, 0, "l4_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
